// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default widths, dense-layer size and the
// dense_feeder state encoding.
package cnn_pkg;

    localparam int CNN_DATA_W   = 8;
    localparam int CNN_ADDR_W   = 10;
    localparam int CNN_NUM_ELEM = 507;

    localparam logic [2:0] FEED_IDLE   = 3'd0;
    localparam logic [2:0] FEED_CLR    = 3'd1;
    localparam logic [2:0] FEED_FETCH  = 3'd2;
    localparam logic [2:0] FEED_STROBE = 3'd3;
    localparam logic [2:0] FEED_RUN    = 3'd4;
    localparam logic [2:0] FEED_TERM   = 3'd5;
    localparam logic [2:0] FEED_WAITQ  = 3'd6;
    localparam logic [2:0] FEED_FIN    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = FEED_IDLE,
        S_CLR    = FEED_CLR,
        S_FETCH  = FEED_FETCH,
        S_STROBE = FEED_STROBE,
        S_RUN    = FEED_RUN,
        S_TERM   = FEED_TERM,
        S_WAITQ  = FEED_WAITQ,
        S_FIN    = FEED_FIN
    } feeder_state_t;

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter with a zero flag; parks at zero until reloaded.
module slot_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/dense_feeder.sv
// Sequences feature/weight pairs into the dense layer, appends a zero-valued
// terminal slot, then waits (bounded) for the quantised neuron result.
module dense_feeder
    import cnn_pkg::*;
#(
    parameter int NUM_ELEM   = CNN_NUM_ELEM,
    parameter int ADDR_W     = CNN_ADDR_W,
    parameter int DATA_W     = CNN_DATA_W,
    parameter int RUN_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_feat,
    input  logic [DATA_W-1:0] mem_wgt,
    output logic              dense_rst,
    output logic              dense_en,
    output logic              dense_div,
    output logic [ADDR_W-1:0] pos_memory,
    output logic [DATA_W-1:0] idata_max,
    output logic [DATA_W-1:0] idata_weight,
    input  logic              quant_ok,
    input  logic [DATA_W-1:0] num_dens,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              err
);

    localparam int CNT_MAX = (RUN_CYCLES > TIMEOUT) ? RUN_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  RUN_LOAD  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(NUM_ELEM - 1);
    localparam logic [ADDR_W-1:0] TERM_POS  = ADDR_W'(NUM_ELEM + 1);

    generate
        if ((NUM_ELEM + 1) >= (1 << ADDR_W)) begin : g_bad_addr_w
            $error("dense_feeder: NUM_ELEM+1 does not fit in ADDR_W bits");
        end
        if (RUN_CYCLES < 1 || TIMEOUT < 1 || NUM_ELEM < 1) begin : g_bad_params
            $error("dense_feeder: NUM_ELEM, RUN_CYCLES and TIMEOUT must be >= 1");
        end
    endgenerate

    feeder_state_t     state_reg;
    logic [ADDR_W-1:0] elem_reg;
    logic              term_armed_reg;

    // Timer 0 paces the hold cycles of each slot, timer 1 bounds the result wait.
    logic [1:0] tmr_load;
    logic [1:0] tmr_zero;

    always_comb begin
        tmr_load    = '0;
        tmr_load[0] = dense_div;
        tmr_load[1] = (state_reg == S_TERM) && term_armed_reg && !dense_div && tmr_zero[0];
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_timer
            slot_timer #(
                .W(CNT_W)
            ) u_timer (
                .clk      (clk),
                .rst      (rst),
                .load     (tmr_load[gi]),
                .load_val ((gi == 0) ? RUN_LOAD : WAIT_LOAD),
                .zero     (tmr_zero[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            elem_reg       <= '0;
            term_armed_reg <= 1'b0;
            busy           <= 1'b0;
            mem_addr       <= '0;
            dense_rst      <= 1'b0;
            dense_en       <= 1'b0;
            dense_div      <= 1'b0;
            pos_memory     <= '0;
            idata_max      <= '0;
            idata_weight   <= '0;
            result         <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_CLR;
                        busy      <= 1'b1;
                        elem_reg  <= '0;
                        dense_rst <= 1'b1;
                        dense_en  <= 1'b0;
                    end
                end
                S_CLR: begin
                    dense_rst <= 1'b0;
                    dense_en  <= 1'b1;
                    mem_addr  <= elem_reg;
                    state_reg <= S_FETCH;
                end
                S_FETCH: begin
                    dense_div <= 1'b1;
                    state_reg <= S_STROBE;
                end
                S_STROBE: begin
                    // Memory data for mem_addr has arrived; it stays put for the whole hold.
                    dense_div    <= 1'b0;
                    idata_max    <= mem_feat;
                    idata_weight <= mem_wgt;
                    pos_memory   <= elem_reg + 1'b1;
                    state_reg    <= S_RUN;
                end
                S_RUN: begin
                    if (tmr_zero[0]) begin
                        if (elem_reg == LAST_ELEM) begin
                            state_reg      <= S_TERM;
                            term_armed_reg <= 1'b0;
                            idata_max      <= '0;
                            idata_weight   <= '0;
                            pos_memory     <= TERM_POS;
                        end else begin
                            elem_reg  <= elem_reg + 1'b1;
                            mem_addr  <= elem_reg + 1'b1;
                            state_reg <= S_FETCH;
                        end
                    end
                end
                S_TERM: begin
                    // Same slot shape as a data slot: lead-in, strobe, then the holds.
                    if (!term_armed_reg) begin
                        term_armed_reg <= 1'b1;
                        dense_div      <= 1'b1;
                    end else if (dense_div) begin
                        dense_div <= 1'b0;
                    end else if (tmr_zero[0]) begin
                        state_reg <= S_WAITQ;
                    end
                end
                S_WAITQ: begin
                    if (quant_ok) begin
                        result    <= num_dens;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        dense_en  <= 1'b0;
                        state_reg <= S_FIN;
                    end else if (tmr_zero[1]) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        dense_en  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_feeder.sv
// Directed bench for dense_feeder: cycle-level timing model plus a behavioural
// memory and dense-layer peer.
module tb_dense_feeder;

    localparam int N    = 3;
    localparam int R    = 4;
    localparam int TO   = 8;
    localparam int SLOT = R + 2;
    localparam int WAITQ_K = 2 + SLOT * (N + 1);
    localparam int ERR_K   = WAITQ_K + TO;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, dense_rst, dense_en, dense_div, done, err;
    logic       quant_ok = 1'b0;
    logic [9:0] mem_addr, pos_memory;
    logic [7:0] mem_feat = '0;
    logic [7:0] mem_wgt = '0;
    logic [7:0] idata_max, idata_weight, result;
    logic [7:0] num_dens = '0;

    logic [7:0] feat_mem [N] = '{8'd2, 8'd3, 8'd4};
    logic [7:0] wgt_mem  [N] = '{8'd5, 8'd6, 8'd7};

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int q_idx = 0;
    int acc = 0;
    int fire_in = 0;
    logic prev_div = 1'b0;
    int div_count = 0;

    dense_feeder #(
        .NUM_ELEM(N), .ADDR_W(10), .DATA_W(8), .RUN_CYCLES(R), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .mem_addr(mem_addr), .mem_feat(mem_feat), .mem_wgt(mem_wgt),
        .dense_rst(dense_rst), .dense_en(dense_en), .dense_div(dense_div),
        .pos_memory(pos_memory), .idata_max(idata_max), .idata_weight(idata_weight),
        .quant_ok(quant_ok), .num_dens(num_dens), .result(result),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read feature memory and weight ROM.
    always @(posedge clk) begin
        if (mem_addr < 10'(N)) begin
            mem_feat <= feat_mem[mem_addr[1:0]];
            mem_wgt  <= wgt_mem[mem_addr[1:0]];
        end else begin
            mem_feat <= '0;
            mem_wgt  <= '0;
        end
    end

    // Dense-layer peer: accumulates the pair presented after each strobe and
    // answers q_idx cycles into the wait once the terminal position is seen.
    always @(posedge clk) begin
        if (rst) begin
            acc      <= 0;
            fire_in  <= 0;
            prev_div <= 1'b0;
            quant_ok <= 1'b0;
        end else begin
            prev_div <= dense_div;
            quant_ok <= (fire_in == 1);
            num_dens <= acc[7:0];
            if (fire_in > 0) fire_in <= fire_in - 1;
            if (dense_rst) acc <= 0;
            else if (prev_div) acc <= acc + int'(idata_max) * int'(idata_weight);
            if (prev_div && pos_memory == 10'(N + 1) && q_idx >= 0) fire_in <= q_idx + 3;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(feat_mem[i]) * int'(wgt_mem[i]);
        return s;
    endfunction

    // Timing model: every output is a function of the cycle offset k from the
    // accepted start, the slot length and the cycle quant_ok was offered.
    initial begin : compare
        int   k, j, ph, t0, done_k, end_k, exp_result;
        bit   active, done_seen, zero_next, can_acc;
        active = 0; done_seen = 0; zero_next = 0; t0 = 0; done_k = 0; exp_result = 0;
        forever begin
            @(negedge clk);
            if (zero_next) begin
                zero_next  = 0;
                exp_result = 0;
                chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
                chk("rst_err", err, 0);             chk("rst_en", dense_en, 0);
                chk("rst_div", dense_div, 0);       chk("rst_drst", dense_rst, 0);
                chk("rst_pos", pos_memory, 0);      chk("rst_imax", idata_max, 0);
                chk("rst_iwgt", idata_weight, 0);   chk("rst_addr", mem_addr, 0);
            end else if (active) begin
                k = cyc - t0;
                end_k = done_seen ? done_k : ERR_K;
                chk("dense_rst", dense_rst, (k == 1));
                chk("dense_div", dense_div, (k >= 3) && ((k - 3) % SLOT == 0) && ((k - 3) / SLOT <= N));
                chk("busy", busy, (k < end_k));
                chk("dense_en", dense_en, (k >= 2) && (k < end_k));
                chk("done", done, done_seen && (k == done_k));
                chk("err", err, !done_seen && (k == ERR_K));
                if (k >= 4) begin
                    j  = (k - 4) / SLOT;
                    ph = (k - 4) % SLOT;
                    if (ph < R && j <= N) begin
                        chk("hold_pos", pos_memory, j + 1);
                        chk("hold_feat", idata_max, (j < N) ? feat_mem[j] : 0);
                        chk("hold_wgt", idata_weight, (j < N) ? wgt_mem[j] : 0);
                    end
                end
                if (k == 3 + SLOT * N) begin
                    chk("term_pos", pos_memory, N + 1);
                    chk("term_feat", idata_max, 0);
                    chk("term_wgt", idata_weight, 0);
                end
                if (k >= 2 && (k - 2) % SLOT == 0 && (k - 2) / SLOT < N)
                    chk("mem_addr", mem_addr, (k - 2) / SLOT);
                if (done_seen && k == done_k) exp_result = exp_sum() % 256;
            end else begin
                chk("idle_busy", busy, 0);   chk("idle_done", done, 0);
                chk("idle_err", err, 0);     chk("idle_en", dense_en, 0);
                chk("idle_div", dense_div, 0); chk("idle_drst", dense_rst, 0);
            end
            chk("result", result, exp_result);
            if (dense_div === 1'b1) div_count++;

            can_acc = 1;
            if (active) begin
                k = cyc - t0;
                if (!done_seen && quant_ok && k >= WAITQ_K && k < ERR_K) begin
                    done_seen = 1;
                    done_k    = k + 1;
                end
                if (done_seen && k == done_k) begin
                    active  = 0;
                    can_acc = 0;
                end else if (!done_seen && k == ERR_K) begin
                    active = 0;
                end else begin
                    can_acc = 0;
                end
            end
            if (rst) begin
                active    = 0;
                zero_next = 1;
            end else if (start && can_acc) begin
                active    = 1;
                t0        = cyc;
                done_seen = 0;
                div_count = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    initial begin : stimulus
        int t;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        step();

        // Run A: nominal, with ignored starts during RUN and FIN.
        q_idx = 0;
        t = cyc; start = 1'b1;
        wait_until(t + 1); start = 1'b0;
        chk("clr_pulse", dense_rst, 1);
        wait_until(t + 5); start = 1'b1;
        wait_until(t + 6); start = 1'b0;
        wait_until(t + 21); chk("term_strobe", dense_div, 1);
        wait_until(t + 22);
        chk("term_pos_lit", pos_memory, 4);
        chk("term_feat_lit", idata_max, 0);
        chk("term_wgt_lit", idata_weight, 0);
        wait_until(t + 27);
        chk("a_done", done, 1);
        chk("a_result", result, 56);
        chk("a_div_count", div_count, 4);
        chk("a_model_sum", acc, 56);
        $display("txn A: result=%0d strobes=%0d", result, div_count);
        start = 1'b1;

        // Run B: back-to-back start in the first idle cycle, slower answer.
        wait_until(t + 28);
        t = t + 28; q_idx = 2;
        wait_until(t + 1); start = 1'b0;
        chk("b2b_clr", dense_rst, 1);
        wait_until(t + 29);
        chk("b_done", done, 1);
        chk("b_result", result, 56);
        $display("txn B: result=%0d", result);
        repeat (3) step();

        // Run C: reset during the hold of element 2.
        q_idx = 0;
        t = cyc; start = 1'b1;
        wait_until(t + 1); start = 1'b0;
        wait_until(t + 11); rst = 1'b1;
        wait_until(t + 12); rst = 1'b0;
        chk("c_busy", busy, 0);
        chk("c_pos", pos_memory, 0);
        chk("c_result", result, 0);
        chk("c_en", dense_en, 0);
        $display("txn C: aborted by reset, busy=%0d", busy);
        wait_until(t + 45);

        // Run D: normal completion after the abort.
        t = cyc; start = 1'b1;
        wait_until(t + 1); start = 1'b0;
        wait_until(t + 27);
        chk("d_done", done, 1);
        chk("d_result", result, 56);
        $display("txn D: result=%0d", result);
        repeat (3) step();

        // Run E: quant_ok never arrives.
        q_idx = -1;
        t = cyc; start = 1'b1;
        wait_until(t + 1); start = 1'b0;
        wait_until(t + 33); chk("e_busy_before", busy, 1);
        wait_until(t + 34);
        chk("e_err", err, 1);
        chk("e_busy", busy, 0);
        chk("e_done", done, 0);
        $display("txn E: timeout err=%0d", err);
        repeat (5) step();

        // Run F: quant_ok in the last wait cycle beats the timeout.
        q_idx = 7;
        t = cyc; start = 1'b1;
        wait_until(t + 1); start = 1'b0;
        wait_until(t + 34);
        chk("f_done", done, 1);
        chk("f_err", err, 0);
        chk("f_result", result, 56);
        $display("txn F: result=%0d err=%0d", result, err);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_feeder.md
Name: dense_feeder

Overview:
- Upstream sequencer for the dense (fully-connected) layer.
- Walks the pooled-feature memory and the weight ROM, and presents one (feature, weight, position) triple per slot on the dense-layer input interface.
- Generates the dense layer's slot strobe, enable and accumulator reset, then waits for the quantised result and returns it with a one-cycle valid pulse.
- Sits between the max-pool output buffer/weight ROM and the dense layer, under control of the top-level CNN sequencer.

Parameters:
- NUM_ELEM, 507, number of feature/weight pairs per neuron.
- ADDR_W, 10, memory address width and width of pos_memory.
- DATA_W, 8, width of feature, weight and result.
- RUN_CYCLES, 4, cycles the dense layer needs per element after the strobe (s0..s3).
- TIMEOUT, 64, maximum cycles to wait for quant_ok.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to compute one neuron; ignored unless idle.
- busy  out  1  high from accepted start until done/err.
- mem_addr  out  ADDR_W  shared read address to the feature memory and weight ROM.
- mem_feat  in  DATA_W  feature read data, valid 1 cycle after mem_addr.
- mem_wgt  in  DATA_W  weight read data, valid 1 cycle after mem_addr.
- dense_rst  out  1  accumulator clear to the dense layer.
- dense_en  out  1  enable to the dense layer.
- dense_div  out  1  slot strobe to the dense layer (restarts its FSM at s0).
- pos_memory  out  ADDR_W  1-based element position.
- idata_max  out  DATA_W  feature presented to the dense layer.
- idata_weight  out  DATA_W  weight presented to the dense layer.
- quant_ok  in  1  dense-layer result-ready.
- num_dens  in  DATA_W  dense-layer quantised result.
- result  out  DATA_W  captured num_dens.
- done  out  1  one-cycle pulse; result valid.
- err  out  1  one-cycle pulse on quant_ok timeout.

Behaviour:
- Reset state: every output is 0, including busy, done, err, dense_en, dense_div, dense_rst, pos_memory, idata_*, result and mem_addr. The FSM goes to IDLE. Reset taken mid-operation aborts immediately, with no done or err pulse.
- FSM states: IDLE, CLR, FETCH, STROBE, RUN, TERM, WAITQ, FIN.
- IDLE: on start, go to CLR, set busy=1 and elem=0.
- CLR (1 cycle):
  - dense_rst=1, dense_en=0.
  - Go to FETCH.
- FETCH (1 cycle):
  - mem_addr=elem.
  - dense_en=1 from here until FIN.
- STROBE (1 cycle):
  - dense_div=1.
  - Register idata_max<=mem_feat, idata_weight<=mem_wgt, pos_memory<=elem+1.
- RUN: hold all data and pos stable for exactly RUN_CYCLES cycles with dense_div=0, counted by run_cnt.
  - At the end, if elem==NUM_ELEM-1, go to TERM.
  - Otherwise increment elem and go to FETCH.
- Slot length is therefore RUN_CYCLES+2 cycles per element, and data never changes while dense_div=0 inside RUN.
- TERM: a terminal slot.
  - One strobe cycle with idata_max=0, idata_weight=0 and pos_memory=NUM_ELEM+1, followed by RUN_CYCLES hold cycles. This triggers the dense layer's completion check while adding 0 to the sum.
  - Then go to WAITQ.
- WAITQ: wait_cnt counts from 0.
  - On quant_ok=1, capture result<=num_dens and go to FIN.
  - If wait_cnt reaches TIMEOUT-1 with no quant_ok, pulse err, clear busy and go to IDLE.
  - quant_ok and timeout in the same cycle: quant_ok wins.
- FIN (1 cycle):
  - done=1, busy=0, dense_en=0.
  - Go to IDLE.
- Latency: start to done = 2 + NUM_ELEM*(RUN_CYCLES+2) + (RUN_CYCLES+1) + quant latency + 1.
- start while busy is ignored, with no queueing.
- start in the FIN cycle is also ignored; start in the first IDLE cycle is accepted, which allows back-to-back operation.
- Widths: elem and pos_memory are ADDR_W bits. NUM_ELEM+1 must fit in ADDR_W; this is checked by an elaboration-time assertion.
- result holds its value until the next done.

Decomposition:
- Shared package cnn_pkg holds:
  - the dense_feeder state encoding (localparams),
  - DATA_W/ADDR_W defaults,
  - NUM_ELEM=507 shared with the dense layer.
- One sub-module, slot_timer: a loadable down-counter with a zero flag. It is reused for run_cnt and wait_cnt.

Test Plan:
- NUM_ELEM=3, RUN_CYCLES=4, memory feat={2,3,4}, wgt={5,6,7}, behavioural dense model.
  - Required: exactly 4 dense_div pulses, at cycles 3, 9, 15, 21 after start.
  - Required: pos_memory=1,2,3,4.
  - Required: data stable on the 4 cycles after each pulse.
  - Required: model sum=56; done pulse with result=num_dens.
- Terminal slot: check idata_max=idata_weight=0 and pos_memory=NUM_ELEM+1 during TERM.
  - Required: dense_rst pulses once, in the cycle after start.
- Timeout: quant_ok tied to 0, TIMEOUT=8.
  - Required: err pulses after 8 WAITQ cycles; busy drops; done is never asserted.
- start asserted during RUN and during FIN.
  - Required: ignored, with no extra dense_div.
  - Required: start in the cycle after done begins a new run, whose CLR pulse appears next cycle.
- rst asserted during the RUN of element 2.
  - Required: next cycle, all outputs are 0 and the FSM is in IDLE, with no done or err.
  - Required: a subsequent start completes normally with the correct result.
- quant_ok asserted in the same cycle wait_cnt hits TIMEOUT-1.
  - Required: done=1, err=0, result captured.
